// File: rtl/adder_pkg.sv
// Shared widths and types for the two-stage pipelined adder.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int ADDER_HALF  = ADDER_WIDTH / 2;

  typedef logic [ADDER_HALF-1:0] half_t;

endpackage

// File: rtl/adder_32bit_pipe_if.sv
// Operand and result handshake bundle between the issue logic, the adder and the consumer.
interface adder_32bit_pipe_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C32;

  modport master (
    output in_valid, A, B, CIN, out_ready,
    input  in_ready, out_valid, S, C32
  );

  modport slave (
    input  in_valid, A, B, CIN, out_ready,
    output in_ready, out_valid, S, C32
  );

endinterface

// File: rtl/add16_cin.sv
// Combinational half-width adder with carry-in; one sits in front of each pipeline stage.
module add16_cin
  import adder_pkg::*;
#(
  parameter int W = ADDER_HALF
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CIN,
  output logic [W-1:0] S,
  output logic         COUT
);

  assign {COUT, S} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, CIN};

endmodule

// File: rtl/adder_32bit_pipe.sv
// Two-stage pipelined adder: low half plus CIN in stage 1, high half plus the
// registered low carry in stage 2, with bubble-free valid/ready flow control.
module adder_32bit_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  adder_32bit_pipe_if.slave bus
);

  localparam int HALF = WIDTH / 2;

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_lo_q, s1_lo_d;
  logic            s1_c_q, s1_c_d;
  logic [HALF-1:0] s1_ahi_q, s1_ahi_d;
  logic [HALF-1:0] s1_bhi_q, s1_bhi_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic            c32_q, c32_d;
  logic            out_valid_q, out_valid_d;

  logic [HALF-1:0] lo_sum_s;
  logic            lo_cout_s;
  logic [HALF-1:0] hi_sum_s;
  logic            hi_cout_s;
  logic            s2_free_s;
  logic            s1_adv_s;
  logic            in_ready_s;
  logic            accept_s;

  add16_cin #(.W(HALF)) u_add_lo (
    .A    (bus.A[HALF-1:0]),
    .B    (bus.B[HALF-1:0]),
    .CIN  (bus.CIN),
    .S    (lo_sum_s),
    .COUT (lo_cout_s)
  );

  add16_cin #(.W(HALF)) u_add_hi (
    .A    (s1_ahi_q),
    .B    (s1_bhi_q),
    .CIN  (s1_c_q),
    .S    (hi_sum_s),
    .COUT (hi_cout_s)
  );

  // A full stage 1 can still accept when it moves on in the same cycle.
  assign s2_free_s  = !out_valid_q || bus.out_ready;
  assign s1_adv_s   = s1_valid_q && s2_free_s;
  assign in_ready_s = !rst && (!s1_valid_q || s1_adv_s);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.C32       = c32_q;

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_c_d      = s1_c_q;
    s1_ahi_d    = s1_ahi_q;
    s1_bhi_d    = s1_bhi_q;
    s_d         = s_q;
    c32_d       = c32_q;
    out_valid_d = out_valid_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_sum_s;
      s1_c_d     = lo_cout_s;
      s1_ahi_d   = bus.A[WIDTH-1:HALF];
      s1_bhi_d   = bus.B[WIDTH-1:HALF];
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_adv_s) begin
      s_d         = {hi_sum_s, s1_lo_q};
      c32_d       = hi_cout_s;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= {HALF{1'b0}};
      s1_c_q      <= 1'b0;
      s1_ahi_q    <= {HALF{1'b0}};
      s1_bhi_q    <= {HALF{1'b0}};
      s_q         <= {WIDTH{1'b0}};
      c32_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_ahi_q    <= s1_ahi_d;
      s1_bhi_q    <= s1_bhi_d;
      s_q         <= s_d;
      c32_q       <= c32_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_adder_32bit_pipe.sv
// Scoreboard bench: the driver pushes A+B+CIN at every accept, an independent
// monitor pops and compares at every output transfer.
module tb_adder_32bit_pipe;
  import adder_pkg::*;

  typedef struct {
    logic [31:0] s;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_32bit_pipe_if bus ();

  adder_32bit_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   or_mode = 0;
  int   accepted = 0;
  int   stalls = 0;
  int   run = 0;
  int   max_run = 0;
  logic bp_done = 1'b0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    exp_t        e;
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    e.s = full[31:0];
    e.c = full[32];
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic acc;
    int   w;
    acc = 1'b0;
    w = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.CIN = c;
    while (!acc && w < 2000) begin
      #1;
      acc = bus.in_ready;
      if (acc) begin
        q.push_back(model(a, b, c));
        accepted++;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (!acc) begin
        @(negedge clk);
        w++;
      end
    end
    bus.in_valid = 1'b0;
    if (!acc) check("drive_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_FFFF;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Output monitor: drives out_ready, checks hold stability and pops the scoreboard.
  initial begin
    logic        have_hold;
    logic [31:0] hs;
    logic        hc;
    exp_t        e;
    have_hold = 1'b0;
    hs = 32'd0;
    hc = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
      #1;
      if (bus.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (have_hold && bus.out_valid) begin
        check("hold_S", 64'(bus.S), 64'(hs));
        check("hold_C32", 64'(bus.C32), 64'(hc));
      end
      have_hold = bus.out_valid && !bus.out_ready;
      hs = bus.S;
      hc = bus.C32;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("sum_S", 64'(bus.S), 64'(e.s));
          check("sum_C32", 64'(bus.C32), 64'(e.c));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    bus.in_valid = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    bus.CIN = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_S", 64'(bus.S), 64'd0);
    check("reset_C32", 64'(bus.C32), 64'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Carry crosses the half boundary; result visible two cycles after the accept cycle.
    or_mode = 0;
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    #2;
    check("basic_lat1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #2;
    check("basic_lat2_valid", 64'(bus.out_valid), 64'd1);
    check("basic_S", 64'(bus.S), 64'h0001_0000);
    check("basic_C32", 64'(bus.C32), 64'd0);
    wait_drain();

    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check("wrap_valid", 64'(bus.out_valid), 64'd1);
    check("wrap_S", 64'(bus.S), 64'h0000_0000);
    check("wrap_C32", 64'(bus.C32), 64'd1);
    wait_drain();

    stalls = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) drive(32'(i), 32'h8000_0000, 1'b0);
    wait_drain();
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_run", 64'(max_run), 64'd8);

    or_mode = 2;
    accepted = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge clk);
    #2;
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    or_mode = 0;
    n = 0;
    while (!bp_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_driver_done", 64'(bp_done), 64'd1);
    wait_drain();
    check("bp_accepted_all", 64'(accepted), 64'd4);

    // Fill both stages, then reset asynchronously mid-cycle.
    or_mode = 2;
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    drive(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    @(negedge clk);
    #2;
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", 64'(bus.out_valid), 64'd0);
    check("async_reset_S", 64'(bus.S), 64'd0);
    check("async_reset_C32", 64'(bus.C32), 64'd0);
    q.delete();
    or_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset2", 64'(bus.in_ready), 64'd1);
    drive(32'd123, 32'd456, 1'b1);
    @(negedge clk);
    #2;
    check("post_reset_lat1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #2;
    check("post_reset_lat2", 64'(bus.out_valid), 64'd1);
    check("post_reset_S", 64'(bus.S), 64'd580);
    wait_drain();

    or_mode = 1;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      ra = pick_operand();
      rb = pick_operand();
      drive(ra, rb, 1'($urandom_range(0, 1)));
    end
    or_mode = 0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
